// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch sequencer: FSM state type,
// branch-target LUT geometry and reset contents, and the decoder encodings
// that the fetch unit cooperates with (halt instruction, branch opcode).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // The decoder supplies a 3-bit target index, so the table depth is fixed.
    localparam int LUT_DEPTH = 8;
    localparam int LUT_IDX_W = 3;

    // Absolute branch targets loaded into the LUT on reset.
    localparam int unsigned BR_LUT_INIT [LUT_DEPTH] = '{
        0, 100, 200, 300, 400, 500, 600, 700
    };

    // Decoder encodings the fetch unit's inputs are derived from.
    localparam logic [8:0] HALT_INSTR = 9'h1FF;
    localparam logic [2:0] BR_OPCODE  = 3'b110;

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch unit's harness, decoder, ALU-flag and LUT-write signals.
//   master : harness/decoder side (drives start, branch_en, zero, pc_targ,
//            ack, lut_wr_en, lut_addr, lut_data; observes prog_ctr,
//            instr_valid, done)
//   slave  : fetch_unit side (the reverse)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_W = 10
);
    import fetch_unit_pkg::*;

    logic                 start;
    logic                 branch_en;
    logic                 zero;
    logic [LUT_IDX_W-1:0] pc_targ;
    logic                 ack;
    logic                 lut_wr_en;
    logic [LUT_IDX_W-1:0] lut_addr;
    logic [PC_W-1:0]      lut_data;
    logic [PC_W-1:0]      prog_ctr;
    logic                 instr_valid;
    logic                 done;

    modport master (
        output start, branch_en, zero, pc_targ, ack,
        output lut_wr_en, lut_addr, lut_data,
        input  prog_ctr, instr_valid, done
    );

    modport slave (
        input  start, branch_en, zero, pc_targ, ack,
        input  lut_wr_en, lut_addr, lut_data,
        output prog_ctr, instr_valid, done
    );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// -----------------------------------------------------------------------------
// fetch_unit_branch_lut
// Branch-target register file: DEPTH entries of PC_W bits.
//   clk, rst : clock, asynchronous active-high reset (loads BR_LUT_INIT)
//   wr_en, wr_addr, wr_data : synchronous write port
//   rd_addr, rd_data        : combinational read port
// A write and a read of the same entry in one cycle return the old value;
// the new value is visible from the following cycle.
// -----------------------------------------------------------------------------
module fetch_unit_branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int DEPTH = LUT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [LUT_IDX_W-1:0] wr_addr,
    input  logic [PC_W-1:0]      wr_data,
    input  logic [LUT_IDX_W-1:0] rd_addr,
    output logic [PC_W-1:0]      rd_data
);

    logic [PC_W-1:0] entries [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= PC_W'(BR_LUT_INIT[i]);
            end
        end else if (wr_en) begin
            entries[wr_addr] <= wr_data;
        end
    end

    assign rd_data = entries[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program counter / instruction-fetch sequencer. Steps the PC one instruction
// per cycle, takes LUT-indexed branches when the decoder flags a branch and
// the ALU zero flag is set, halts on the decoder's halt acknowledge or when
// the PC would run past the end of the program, and reports completion.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_unit_if.slave
//     start              harness go pulse, (re)starts at PC 0
//     branch_en/zero     taken-branch condition
//     pc_targ            branch-target LUT index
//     ack                halt instruction at current PC
//     lut_wr_en/addr/data LUT write port
//     prog_ctr           instruction ROM address
//     instr_valid        high while running
//     done               high once halted
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int PROG_LEN  = 1024,
    parameter int LUT_DEPTH = fetch_unit_pkg::LUT_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);

    localparam logic [PC_W-1:0] LAST_PC      = PC_W'(PROG_LEN - 1);
    // One extra bit so PROG_LEN == 2**PC_W is representable in the compare.
    localparam logic [PC_W:0]   PROG_LEN_EXT = (PC_W + 1)'(PROG_LEN);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lut_target;
    logic            target_oob;

    fetch_unit_branch_lut #(
        .PC_W  (PC_W),
        .DEPTH (LUT_DEPTH)
    ) u_branch_lut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.lut_wr_en),
        .wr_addr (bus.lut_addr),
        .wr_data (bus.lut_data),
        .rd_addr (bus.pc_targ),
        .rd_data (lut_target)
    );

    // Branch targets outside the program halt instead of jumping.
    assign target_oob = ({1'b0, lut_target} >= PROG_LEN_EXT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (bus.start) begin
                    // Restart discards whatever instruction is in flight.
                    pc_d = '0;
                end else if (bus.ack) begin
                    // PC stays on the halt instruction.
                    state_d = HALT;
                end else if (bus.branch_en && bus.zero) begin
                    if (target_oob) begin
                        state_d = HALT;
                    end else begin
                        pc_d = lut_target;
                    end
                end else if (pc_q == LAST_PC) begin
                    // Runaway guard: never wrap back to 0.
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.instr_valid = (state_q == RUN);
    assign bus.done        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Two fetch units share one stimulus stream: instance 0 with the full program
// length (1024) and instance 1 with a 16-word program, so the end-of-program
// and out-of-range-branch guards are exercised alongside the normal flow.
// A behavioural model of both tracks the expected PC / valid / done.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W = 10;
    localparam int NI   = 2;
    localparam int PLEN [NI] = '{1024, 16};
    localparam int LUT_INIT [8] = '{0, 100, 200, 300, 400, 500, 600, 700};

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic            start     = 1'b0;
    logic            branch_en = 1'b0;
    logic            zero      = 1'b0;
    logic [2:0]      pc_targ   = '0;
    logic            ack       = 1'b0;
    logic            lut_wr_en = 1'b0;
    logic [2:0]      lut_addr  = '0;
    logic [PC_W-1:0] lut_data  = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(PC_W)) ifa ();
    fetch_unit_if #(.PC_W(PC_W)) ifb ();

    assign ifa.start = start;      assign ifb.start = start;
    assign ifa.branch_en = branch_en; assign ifb.branch_en = branch_en;
    assign ifa.zero = zero;        assign ifb.zero = zero;
    assign ifa.pc_targ = pc_targ;  assign ifb.pc_targ = pc_targ;
    assign ifa.ack = ack;          assign ifb.ack = ack;
    assign ifa.lut_wr_en = lut_wr_en; assign ifb.lut_wr_en = lut_wr_en;
    assign ifa.lut_addr = lut_addr; assign ifb.lut_addr = lut_addr;
    assign ifa.lut_data = lut_data; assign ifb.lut_data = lut_data;

    fetch_unit #(.PC_W(PC_W), .PROG_LEN(1024)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    fetch_unit #(.PC_W(PC_W), .PROG_LEN(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    logic [PC_W-1:0] dut_pc    [NI];
    logic            dut_valid [NI];
    logic            dut_done  [NI];

    assign dut_pc[0] = ifa.prog_ctr;    assign dut_pc[1] = ifb.prog_ctr;
    assign dut_valid[0] = ifa.instr_valid; assign dut_valid[1] = ifb.instr_valid;
    assign dut_done[0] = ifa.done;      assign dut_done[1] = ifb.done;

    // ---------------- behavioural model ----------------
    int m_st  [NI] = '{M_IDLE, M_IDLE};
    int m_pc  [NI] = '{0, 0};
    int m_lut [NI][8];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_st[k] = M_IDLE;
                m_pc[k] = 0;
                for (int j = 0; j < 8; j++) m_lut[k][j] = LUT_INIT[j];
            end else begin
                int tgt;
                tgt = m_lut[k][pc_targ];
                if (m_st[k] == M_RUN) begin
                    if (start)                     m_pc[k] = 0;
                    else if (ack)                  m_st[k] = M_HALT;
                    else if (branch_en && zero) begin
                        if (tgt >= PLEN[k])        m_st[k] = M_HALT;
                        else                       m_pc[k] = tgt;
                    end
                    else if (m_pc[k] == PLEN[k] - 1) m_st[k] = M_HALT;
                    else                           m_pc[k] = m_pc[k] + 1;
                end else if (start) begin
                    m_st[k] = M_RUN;
                    m_pc[k] = 0;
                end
                // Table update lands after the branch has read the old entry.
                if (lut_wr_en) m_lut[k][lut_addr] = int'(lut_data);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model prog_ctr[%0d]", k), int'(dut_pc[k]), m_pc[k]);
            chk($sformatf("model instr_valid[%0d]", k), int'(dut_valid[k]), int'(m_st[k] == M_RUN));
            chk($sformatf("model done[%0d]", k), int'(dut_done[k]), int'(m_st[k] == M_HALT));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        start = 1'b0; branch_en = 1'b0; zero = 1'b0; pc_targ = '0;
        ack = 1'b0; lut_wr_en = 1'b0; lut_addr = '0; lut_data = '0;
    endtask

    task automatic lit(input string name, input int k, input int pc, input int v, input int d);
        chk({name, " pc"},    int'(dut_pc[k]),    pc);
        chk({name, " valid"}, int'(dut_valid[k]), v);
        chk({name, " done"},  int'(dut_done[k]),  d);
    endtask

    initial begin
        #1 rst = 1'b1;
        tick(2);
        lit("reset a", 0, 0, 0, 0);
        lit("reset b", 1, 0, 0, 0);
        rst = 1'b0;

        // Sequential fetch, then halt on ack at PC 5.
        start = 1'b1; tick(); start = 1'b0;
        lit("start a", 0, 0, 1, 0);
        tick(5);
        lit("step5 a", 0, 5, 1, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        lit("ack a", 0, 5, 0, 1);
        lit("ack b", 1, 5, 0, 1);
        tick();
        lit("halt hold a", 0, 5, 0, 1);

        // Taken branch via LUT[3]=40, then not-taken branch steps.
        lut_wr_en = 1'b1; lut_addr = 3'd3; lut_data = 10'd40; tick(); clr();
        start = 1'b1; tick(); start = 1'b0;
        tick(7);
        lit("pc7 a", 0, 7, 1, 0);
        branch_en = 1'b1; zero = 1'b1; pc_targ = 3'd3; tick(); clr();
        lit("br taken a", 0, 40, 1, 0);
        lit("br oob b", 1, 7, 0, 1);
        start = 1'b1; tick(); start = 1'b0;
        tick(7);
        branch_en = 1'b1; zero = 1'b0; pc_targ = 3'd3; tick(); clr();
        lit("br not taken a", 0, 8, 1, 0);
        lit("br not taken b", 1, 8, 1, 0);

        // Same-edge write and branch: old entry used, new one next time.
        branch_en = 1'b1; zero = 1'b1; pc_targ = 3'd3;
        lut_wr_en = 1'b1; lut_addr = 3'd3; lut_data = 10'd99;
        tick(); clr();
        lit("rbw old a", 0, 40, 1, 0);
        tick();
        branch_en = 1'b1; zero = 1'b1; pc_targ = 3'd3; tick(); clr();
        lit("rbw new a", 0, 99, 1, 0);

        // End-of-program guard on the 16-word instance.
        start = 1'b1; tick(); start = 1'b0;
        tick(15);
        lit("pc15 b", 1, 15, 1, 0);
        tick();
        lit("runaway b", 1, 15, 0, 1);
        lit("past15 a", 0, 16, 1, 0);
        tick();
        lit("runaway hold b", 1, 15, 0, 1);
        start = 1'b1; lut_wr_en = 1'b1; lut_addr = 3'd5; lut_data = 10'd20;
        tick(); clr();
        branch_en = 1'b1; zero = 1'b1; pc_targ = 3'd5; tick(); clr();
        lit("tgt20 b", 1, 0, 0, 1);
        lit("tgt20 a", 0, 20, 1, 0);

        // Restart in RUN and in HALT.
        start = 1'b1; tick(); start = 1'b0;
        tick(12);
        lit("pc12 a", 0, 12, 1, 0);
        start = 1'b1; tick(); start = 1'b0;
        lit("restart run a", 0, 0, 1, 0);
        tick(3);
        ack = 1'b1; tick(); ack = 1'b0;
        lit("halt pc3 a", 0, 3, 0, 1);
        start = 1'b1; tick(); start = 1'b0;
        lit("restart halt a", 0, 0, 1, 0);
        tick();
        lit("resume a", 0, 1, 1, 0);

        // Asynchronous reset between edges, inputs ignored until start.
        tick(2);
        #2 rst = 1'b1;
        #1;
        lit("async rst a", 0, 0, 0, 0);
        lit("async rst b", 1, 0, 0, 0);
        tick();
        rst = 1'b0;
        branch_en = 1'b1; zero = 1'b1; ack = 1'b1; pc_targ = 3'd3;
        tick(2); clr();
        lit("idle ignore a", 0, 0, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        branch_en = 1'b1; zero = 1'b1; pc_targ = 3'd3; tick(); clr();
        lit("lut reinit a", 0, 300, 1, 0);
        lit("lut reinit b", 1, 1, 0, 1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
